// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP multiply/divide issue sequencer.
package fpu_pkg;

  localparam logic [5:0] OP_FMUL  = 6'h37;
  localparam logic [5:0] OP_FDIV  = 6'h38;
  localparam int         LAT_FMUL = 14;
  localparam int         LAT_FDIV = 20;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

endpackage

// File: rtl/fpu_muldiv_issue.sv
// Issue/retire sequencer in front of the FP mul/div unit. One vector op in
// flight: accept, hold operands to the unit until finish, return result.
// Optional FPU_MD_TIMEOUT_EN: abort BUSY with out_err when the unit overruns
// its expected latency by two cycles.
module fpu_muldiv_issue
  import fpu_pkg::*;
#(
  parameter int          N             = 32,
  parameter int          L             = 4,
  parameter int          LATENCY_FMULT = LAT_FMUL,
  parameter int          LATENCY_FDIV  = LAT_FDIV,
  parameter logic [5:0]  FMUL          = OP_FMUL,
  parameter logic [5:0]  FDIV          = OP_FDIV,
  parameter int          WIDTH         = $clog2(LATENCY_FDIV + 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [N*L-1:0]   in_a,
  input  logic [N*L-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*L-1:0]   out_data,
  output logic             out_err,
  output logic             fpu_ivalid,
  output logic             fpu_stall,
  output logic [5:0]       fpu_opcode,
  output logic [N*L-1:0]   fpu_a,
  output logic [N*L-1:0]   fpu_b,
  input  logic [N*L-1:0]   fpu_o,
  input  logic             fpu_finish
);

  md_state_t            state_q, state_d;
  logic [5:0]           op_q, op_d;
  logic [N*L-1:0]       a_q, a_d, b_q, b_d;
  logic [N*L-1:0]       data_q, data_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     lim;

  // Overdue mark for the op in flight; the counter stops there so a hung
  // unit reads as this value rather than a wrapped count.
  assign lim = (op_q == FDIV) ? WIDTH'(LATENCY_FDIV + 2) : WIDTH'(LATENCY_FMULT + 2);

  // Handshake and unit controls are pure decodes of the registered state.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign fpu_ivalid = (state_q == BUSY);
  assign fpu_stall  = (state_q == BUSY);
  assign fpu_opcode = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign out_data   = data_q;
  assign out_err    = err_q;

  // Next-state and datapath register loads.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_opcode == FMUL || in_opcode == FDIV) begin
            op_d    = in_opcode;
            a_d     = in_a;
            b_d     = in_b;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            // Illegal op never reaches the unit.
            data_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt_q != lim) cnt_d = cnt_q + 1'b1;
        if (fpu_finish) begin
          data_d  = fpu_o;
          err_d   = 1'b0;
          state_d = DONE;
        end
`ifdef FPU_MD_TIMEOUT_EN
        else if (cnt_q >= lim) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; synchronous reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
